multicycle_control: RTL and testbench



---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// multicycle_control : RV32I multi-cycle main FSM with retired-instruction count
// Revision 1.0
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        alu_zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  IMM_Src,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    localparam logic [3:0] C_FETCH    = 4'd0;
    localparam logic [3:0] C_DECODE   = 4'd1;
    localparam logic [3:0] C_MEMADR   = 4'd2;
    localparam logic [3:0] C_MEMREAD  = 4'd3;
    localparam logic [3:0] C_MEMWB    = 4'd4;
    localparam logic [3:0] C_MEMWRITE = 4'd5;
    localparam logic [3:0] C_EXECR    = 4'd6;
    localparam logic [3:0] C_EXECI    = 4'd7;
    localparam logic [3:0] C_ALUWB    = 4'd8;
    localparam logic [3:0] C_BRANCH   = 4'd9;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_AND = 3'b010;
    localparam logic [2:0] C_OR  = 3'b011;
    localparam logic [2:0] C_XOR = 3'b100;
    localparam logic [2:0] C_SLT = 3'b101;
    localparam logic [2:0] C_SLL = 3'b110;
    localparam logic [2:0] C_SRL = 3'b111;

    logic [3:0]  state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic       w_is_load, w_is_store, w_is_rtype, w_is_itype, w_is_branch;
    logic       w_is_beq, w_is_bne;
    logic [2:0] w_alu_op;
    logic       w_alu_bad;
    logic       w_instr_illegal;

    assign w_is_load   = (opcode == 7'b0000011);
    assign w_is_store  = (opcode == 7'b0100011);
    assign w_is_rtype  = (opcode == 7'b0110011);
    assign w_is_itype  = (opcode == 7'b0010011);
    assign w_is_branch = (opcode == 7'b1100011);
    assign w_is_beq    = w_is_branch & (funct3 == 3'b000);
    assign w_is_bne    = w_is_branch & (funct3 == 3'b001);

    // funct3 decode shared by EXECR/EXECI; sub only exists in R-type
    always_comb begin
        w_alu_op  = C_ADD;
        w_alu_bad = 1'b0;
        case (funct3)
            3'b000:  w_alu_op = (w_is_rtype & funct7_5) ? C_SUB : C_ADD;
            3'b001:  w_alu_op = C_SLL;
            3'b010:  w_alu_op = C_SLT;
            3'b011:  w_alu_bad = 1'b1;
            3'b100:  w_alu_op = C_XOR;
            3'b101: begin
                w_alu_op  = C_SRL;
                w_alu_bad = funct7_5;
            end
            3'b110:  w_alu_op = C_OR;
            default: w_alu_op = C_AND;
        endcase
    end

    assign w_instr_illegal =
        ~(w_is_load | w_is_store | w_is_rtype | w_is_itype | w_is_branch) |
        ((w_is_rtype | w_is_itype) & w_alu_bad) |
        (w_is_branch & ~(w_is_beq | w_is_bne));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= C_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = C_FETCH;
        case (state_q)
            C_FETCH:    state_d = mem_ready ? C_DECODE : C_FETCH;
            C_DECODE: begin
                if (w_instr_illegal)                state_d = C_FETCH;
                else if (w_is_load | w_is_store)    state_d = C_MEMADR;
                else if (w_is_rtype)                state_d = C_EXECR;
                else if (w_is_itype)                state_d = C_EXECI;
                else                                state_d = C_BRANCH;
            end
            C_MEMADR:   state_d = w_is_store ? C_MEMWRITE : C_MEMREAD;
            C_MEMREAD:  state_d = mem_ready ? C_MEMWB : C_MEMREAD;
            C_MEMWB:    state_d = C_FETCH;
            C_MEMWRITE: state_d = mem_ready ? C_FETCH : C_MEMWRITE;
            C_EXECR:    state_d = C_ALUWB;
            C_EXECI:    state_d = C_ALUWB;
            C_ALUWB:    state_d = C_FETCH;
            C_BRANCH:   state_d = C_FETCH;
            default:    state_d = C_FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        IMM_Src     = 2'b00;
        alu_control = C_ADD;
        illegal     = 1'b0;
        retire      = 1'b0;
        case (state_q)
            C_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            C_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                IMM_Src   = 2'b10;
                illegal   = w_instr_illegal;
            end
            C_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                IMM_Src   = w_is_store ? 2'b01 : 2'b00;
            end
            C_MEMREAD: begin
                adr_src = 1'b1;
            end
            C_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            C_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            C_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_op;
            end
            C_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_op;
            end
            C_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            C_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = C_SUB;
                retire      = 1'b1;
                pc_write    = (w_is_beq & alu_zero) | (w_is_bne & ~alu_zero);
            end
            default: ;
        endcase
    end

    assign instret_d = instret_q + {31'd0, retire};
    assign instret   = instret_q;
    assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_multicycle_control : instruction-level reference model bench for the FSM
// Revision 1.0
// ============================================================================
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        alu_zero;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, IMM_Src;
    logic [2:0]  alu_control;
    logic        illegal, retire;
    logic [31:0] instret;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .opcode(opcode),
        .funct3(funct3), .funct7_5(funct7_5), .alu_zero(alu_zero),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .IMM_Src(IMM_Src),
        .alu_control(alu_control), .illegal(illegal), .retire(retire),
        .instret(instret), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_write, adr_src, mem_write, ir_write, reg_write;
        logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
        logic [2:0] alu_control;
        logic       illegal, retire;
    } ctl_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_BNE = 5, K_ILL = 6;

    typedef struct {
        string      name;
        int         kind;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] alu;
    } instr_t;

    instr_t      tbl[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_instret;

    function automatic ctl_t observed();
        ctl_t c;
        c = '{state, pc_write, adr_src, mem_write, ir_write, reg_write,
              result_src, alu_src_a, alu_src_b, IMM_Src, alu_control, illegal, retire};
        return c;
    endfunction

    function automatic ctl_t blank(input logic [3:0] s);
        ctl_t c;
        c = '0;
        c.st = s;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int find(input string n);
        foreach (tbl[i]) if (tbl[i].name == n) return i;
        return 0;
    endfunction

    // Expand one instruction into its cycle-by-cycle expected control words,
    // then play it against the DUT. Entered and left at posedge+1.
    task automatic run_instr(input int idx, input int wf, input int wm, input logic z);
        instr_t e;
        ctl_t   c;
        ctl_t   q[$];
        logic   mq[$];
        e = tbl[idx];
        opcode = e.op; funct3 = e.f3; funct7_5 = e.f7; alu_zero = z;

        for (int i = 0; i <= wf; i++) begin
            c = blank(4'd0); c.alu_src_b = 2'b10; c.result_src = 2'b10;
            c.pc_write = (i == wf); c.ir_write = (i == wf);
            q.push_back(c); mq.push_back(i == wf);
        end
        c = blank(4'd1); c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 2'b10;
        c.illegal = (e.kind == K_ILL);
        q.push_back(c); mq.push_back(1'($urandom));

        case (e.kind)
            K_LW, K_SW: begin
                c = blank(4'd2); c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
                c.imm_src = (e.kind == K_SW) ? 2'b01 : 2'b00;
                q.push_back(c); mq.push_back(1'($urandom));
                for (int i = 0; i <= wm; i++) begin
                    if (e.kind == K_LW) begin
                        c = blank(4'd3); c.adr_src = 1'b1;
                    end else begin
                        c = blank(4'd5); c.adr_src = 1'b1; c.mem_write = 1'b1; c.retire = (i == wm);
                    end
                    q.push_back(c); mq.push_back(i == wm);
                end
                if (e.kind == K_LW) begin
                    c = blank(4'd4); c.result_src = 2'b01; c.reg_write = 1'b1; c.retire = 1'b1;
                    q.push_back(c); mq.push_back(1'($urandom));
                end
            end
            K_R, K_I: begin
                c = blank((e.kind == K_R) ? 4'd6 : 4'd7); c.alu_src_a = 2'b10;
                c.alu_src_b = (e.kind == K_R) ? 2'b00 : 2'b01; c.alu_control = e.alu;
                q.push_back(c); mq.push_back(1'($urandom));
                c = blank(4'd8); c.reg_write = 1'b1; c.retire = 1'b1;
                q.push_back(c); mq.push_back(1'($urandom));
            end
            K_BEQ, K_BNE: begin
                c = blank(4'd9); c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.retire = 1'b1;
                c.pc_write = (e.kind == K_BEQ) ? z : ~z;
                q.push_back(c); mq.push_back(1'($urandom));
            end
            default: ;
        endcase

        foreach (q[i]) begin
            mem_ready = mq[i];
            @(negedge clk);
            chk($sformatf("%s step%0d ctl", e.name, i), 32'(observed()), 32'(q[i]));
            chk($sformatf("%s step%0d instret", e.name, i), instret, exp_instret);
            if (q[i].retire) exp_instret = exp_instret + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tbl.push_back('{"lw",   K_LW,  7'b0000011, 3'b010, 1'b0, 3'b000});
        tbl.push_back('{"sw",   K_SW,  7'b0100011, 3'b010, 1'b0, 3'b000});
        tbl.push_back('{"add",  K_R,   7'b0110011, 3'b000, 1'b0, 3'b000});
        tbl.push_back('{"sub",  K_R,   7'b0110011, 3'b000, 1'b1, 3'b001});
        tbl.push_back('{"sll",  K_R,   7'b0110011, 3'b001, 1'b0, 3'b110});
        tbl.push_back('{"slt",  K_R,   7'b0110011, 3'b010, 1'b0, 3'b101});
        tbl.push_back('{"xor",  K_R,   7'b0110011, 3'b100, 1'b0, 3'b100});
        tbl.push_back('{"srl",  K_R,   7'b0110011, 3'b101, 1'b0, 3'b111});
        tbl.push_back('{"or",   K_R,   7'b0110011, 3'b110, 1'b0, 3'b011});
        tbl.push_back('{"and",  K_R,   7'b0110011, 3'b111, 1'b0, 3'b010});
        tbl.push_back('{"addi", K_I,   7'b0010011, 3'b000, 1'b1, 3'b000});
        tbl.push_back('{"slli", K_I,   7'b0010011, 3'b001, 1'b0, 3'b110});
        tbl.push_back('{"slti", K_I,   7'b0010011, 3'b010, 1'b0, 3'b101});
        tbl.push_back('{"xori", K_I,   7'b0010011, 3'b100, 1'b0, 3'b100});
        tbl.push_back('{"srli", K_I,   7'b0010011, 3'b101, 1'b0, 3'b111});
        tbl.push_back('{"ori",  K_I,   7'b0010011, 3'b110, 1'b0, 3'b011});
        tbl.push_back('{"andi", K_I,   7'b0010011, 3'b111, 1'b0, 3'b010});
        tbl.push_back('{"beq",  K_BEQ, 7'b1100011, 3'b000, 1'b0, 3'b000});
        tbl.push_back('{"bne",  K_BNE, 7'b1100011, 3'b001, 1'b0, 3'b000});
        tbl.push_back('{"jal",  K_ILL, 7'b1101111, 3'b000, 1'b0, 3'b000});
        tbl.push_back('{"i011", K_ILL, 7'b0010011, 3'b011, 1'b0, 3'b000});
        tbl.push_back('{"r011", K_ILL, 7'b0110011, 3'b011, 1'b0, 3'b000});
        tbl.push_back('{"sra",  K_ILL, 7'b0110011, 3'b101, 1'b1, 3'b000});
        tbl.push_back('{"srai", K_ILL, 7'b0010011, 3'b101, 1'b1, 3'b000});
        tbl.push_back('{"blt",  K_ILL, 7'b1100011, 3'b100, 1'b0, 3'b000});
        tbl.push_back('{"op0",  K_ILL, 7'b0000000, 3'b000, 1'b0, 3'b000});

        rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; alu_zero = 1'b0;
        exp_instret = 32'd0;
        @(negedge clk);
        begin
            ctl_t r;
            r = blank(4'd0); r.alu_src_b = 2'b10; r.result_src = 2'b10;
            chk("reset ctl", 32'(observed()), 32'(r));
            chk("reset instret", instret, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(find("add"), 0, 0, 1'b0);
        chk("add instret", instret, 32'd1);
        run_instr(find("lw"), 2, 3, 1'b0);
        run_instr(find("sw"), 1, 2, 1'b1);
        run_instr(find("beq"), 0, 0, 1'b1);
        run_instr(find("beq"), 0, 0, 1'b0);
        run_instr(find("bne"), 0, 0, 1'b1);
        run_instr(find("bne"), 0, 0, 1'b0);
        run_instr(find("jal"), 0, 0, 1'b0);
        run_instr(find("i011"), 0, 0, 1'b0);
        chk("after illegal instret", instret, 32'd7);

        foreach (tbl[i]) run_instr(i, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom));
        for (int n = 0; n < 80; n++)
            run_instr(int'($urandom_range(0, tbl.size() - 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));

        // Counter wrap: preload all-ones, two branches retire
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(find("beq"), 0, 0, 1'b1);
        run_instr(find("bne"), 0, 0, 1'b1);
        @(negedge clk);
        chk("wrap instret", instret, 32'h0000_0001);
        @(posedge clk); #1;

        // Abort an lw in MEMREAD with reset
        opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort pre state", 32'(state), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort instret", instret, 32'd0);
        chk("abort writes", {29'd0, retire, reg_write, mem_write}, 32'd0);
        @(posedge clk); #1;
        chk("abort held state", 32'(state), 32'd0);
        rst_n = 1'b1;
        exp_instret = 32'd0;
        run_instr(find("ori"), 1, 0, 1'b0);
        chk("post-reset instret", instret, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
